chan_endpoint: RTL
==================

# chan_endpoint

Channel-side responder for the host channel interface driven by `comm_fpga_fx2`, sitting in the `clk_fx2` domain between that module and the DAC/ADC logic. Decodes `chanAddr` and services host writes (h2f) and host reads (f2h). It provides:
- a 16-byte control register file, exported as a flat bus;
- a loopback FIFO for link testing;
- an optional status channel.

## Interface
Parameters:
- `FIFO_DEPTH_LOG2`, default 4 — loopback FIFO holds 2^N bytes; legal range 1..7.

Ports:
- `clk_fx2`  in  1  — 48 MHz FX2 clock; all state on its rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `chanAddr`  in  7  — selected channel.
- `h2fData`  in  8  — host write data.
- `h2fValid`  in  1  — host write byte present.
- `h2fReady`  out  1  — endpoint can accept a write byte.
- `f2hData`  out  8  — host read data.
- `f2hValid`  out  1  — endpoint has a read byte.
- `f2hReady`  in  1  — host will take a read byte.
- `regs_out`  out  128  — register file; byte k at bits [8k+7:8k].

## Operation
- **Transfer rule.** A transfer occurs on a rising edge where valid and ready are both high. The h2f and f2h directions are independent and may both transfer in the same cycle.
- **Channels 0x00–0x0F (registers).**
  - `h2fReady` = 1.
  - A write stores `h2fData` into reg[chanAddr] at the transfer edge.
  - `f2hValid` = 1; `f2hData` = reg[chanAddr], combinational from current state.
  - A read and write in the same cycle returns the old value.
- **Channel 0x10 (loopback FIFO).**
  - `h2fReady` = !full; a write pushes one byte.
  - `f2hValid` = !empty; `f2hData` = head byte; a read pops one byte.
  - Simultaneous push and pop leaves the count unchanged.
  - A push is never performed while full, and a pop never while empty.
  - Pointers are `FIFO_DEPTH_LOG2` bits and wrap modulo depth.
  - Count is `FIFO_DEPTH_LOG2`+1 bits, range 0..2^N.
- **Channel 0x11 (status).** Defined only with the macro; see Configuration.
- **All other channels.**
  - `h2fReady` = 1; writes are discarded.
  - `f2hValid` = 1; `f2hData` = 0x00.
- **`regs_out`.** Driven directly from register flops; no added latency beyond the write edge.

## Timing
- **Reset values.**
  - All registers = 0x00, so `regs_out` = 0.
  - FIFO empty, count = 0, pointers = 0.
  - `f2hValid`/`h2fReady` follow decode: on channel 0x10 after reset, `h2fReady` = 1 and `f2hValid` = 0.
  - `f2hData` = 0x00 when the channel is 0x10 and the FIFO is empty.
- **Latency.**
  - Register write is visible on `f2hData`/`regs_out` the cycle after the write edge.
  - A FIFO push into an empty FIFO raises `f2hValid` the next cycle; there is no fall-through.
- **Decode timing.** `h2fReady`, `f2hValid` and `f2hData` are combinational from `chanAddr` and registered state. A `chanAddr` change takes effect in the same cycle.
- **Reset mid-operation.** Reset asserted during a burst clears everything immediately, asynchronously. Bytes in flight are lost. The first edge after reset release may transfer.
- **Full/empty boundaries.**
  - At count = 2^N, `h2fReady` drops in the cycle after the final push.
  - At count = 0, `f2hValid` drops in the cycle after the final pop.

## Configuration
- `CHAN_ENDPOINT_STATUS_EN` defined:
  - Channel 0x11 reads {`FIFO_DEPTH_LOG2`+1 bit count, zero-extended to 8}, with `f2hValid` = 1.
  - Writes of any value to 0x11 flush the FIFO: count = 0, pointers = 0 at the transfer edge. A flush takes priority over a same-cycle pop; the pop is ignored.
- Not defined: channel 0x11 behaves as an unmapped channel (reads 0x00, writes discarded), and no flush logic is built.

## Test plan
- Reset, then read channels 0x00–0x0F -> all return 0x00 and `regs_out` = 0.
- Write 0xA5 to ch 0x03 and 0x5A to ch 0x0F, then read both -> 0xA5 and 0x5A; `regs_out`[31:24] = 0xA5 and [127:120] = 0x5A.
- Default depth 16: push 0x00..0x0F to ch 0x10 with `h2fValid` held high -> `h2fReady` low after the 16th push. A 17th byte 0xFF is not accepted. Read 16 -> returns 0x00..0x0F in order, then `f2hValid` = 0.
- Wrap and simultaneous transfer:
  - Push 10, pop 10, push 12 (pointer wrap).
  - Then hold push and pop together for 5 cycles -> count stays at 12 and read order is preserved.
- With `CHAN_ENDPOINT_STATUS_EN`: push 7, read ch 0x11 -> 0x07. Write 0x00 to ch 0x11 -> ch 0x11 reads 0x00 and ch 0x10 `f2hValid` = 0. Without the macro, ch 0x11 reads 0x00 and the write leaves the FIFO count at 7.
- Assert `reset` low mid-burst (after 5 pushes and 3 register writes) -> FIFO empty and `regs_out` = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/chan_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : chan_endpoint
// Purpose  : Channel-side responder for the FX2 host channel interface.
//            Decodes chanAddr and services host writes (h2f) and reads (f2h):
//              0x00-0x0F : 16-byte control register file (exported on regs_out)
//              0x10      : loopback FIFO, 2**FIFO_DEPTH_LOG2 bytes deep
//              0x11      : FIFO status/flush channel (only when the build
//                          macro CHAN_ENDPOINT_STATUS_EN is defined)
//              others    : always ready, writes dropped, reads return 0x00
// Config   : `define CHAN_ENDPOINT_STATUS_EN to build the status channel.
// Ports    : clk_fx2   in   1   FX2 clock, all state on its rising edge
//            reset     in   1   asynchronous, active-low reset
//            chanAddr  in   7   selected channel
//            h2fData   in   8   host write data
//            h2fValid  in   1   host write byte present
//            h2fReady  out  1   endpoint can accept a write byte
//            f2hData   out  8   host read data
//            f2hValid  out  1   endpoint has a read byte
//            f2hReady  in   1   host will take a read byte
//            regs_out  out  128 register file, byte k at [8k+7:8k]
// Revision : 1.0 - initial release
// ============================================================================
module chan_endpoint #(
  parameter int FIFO_DEPTH_LOG2 = 4   // legal range 1..7
) (
  input  logic         clk_fx2,
  input  logic         reset,
  input  logic [6:0]   chanAddr,
  input  logic [7:0]   h2fData,
  input  logic         h2fValid,
  output logic         h2fReady,
  output logic [7:0]   f2hData,
  output logic         f2hValid,
  input  logic         f2hReady,
  output logic [127:0] regs_out
);

  localparam int c_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] c_FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2-1:0] c_PTR_ONE = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0] c_CNT_ONE = (FIFO_DEPTH_LOG2 + 1)'(1);

  // --------------------------------------------------------------------------
  // Channel decode
  // --------------------------------------------------------------------------
  logic w_sel_reg;
  logic w_sel_fifo;

  assign w_sel_reg  = (chanAddr[6:4] == 3'b000);
  assign w_sel_fifo = (chanAddr == 7'h10);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [127:0] r_regs;
  logic [6:0]   w_reg_lsb;
  logic [7:0]   w_reg_rd;

  assign w_reg_lsb = {chanAddr[3:0], 3'b000};
  assign w_reg_rd  = r_regs[w_reg_lsb +: 8];

  always_ff @(posedge clk_fx2 or negedge reset) begin
    if (!reset) begin
      r_regs <= '0;
    end else if (w_sel_reg && h2fValid) begin
      r_regs[w_reg_lsb +: 8] <= h2fData;
    end
  end

  assign regs_out = r_regs;

  // --------------------------------------------------------------------------
  // Loopback FIFO
  // --------------------------------------------------------------------------
  logic [7:0]                 r_mem [c_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic [FIFO_DEPTH_LOG2-1:0] w_wr_ptr_nxt;
  logic [FIFO_DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [FIFO_DEPTH_LOG2:0]   w_count_nxt;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;

  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);
  // Handshake gating keeps push-while-full and pop-while-empty impossible.
  assign w_push  = w_sel_fifo && h2fValid && !w_full;
  assign w_pop   = w_sel_fifo && f2hReady && !w_empty;

`ifdef CHAN_ENDPOINT_STATUS_EN
  logic w_sel_stat;
  logic w_flush;
  logic [7:0] w_stat_byte;

  assign w_sel_stat = (chanAddr == 7'h11);
  assign w_flush    = w_sel_stat && h2fValid;

  always_comb begin
    w_stat_byte = '0;
    w_stat_byte[FIFO_DEPTH_LOG2:0] = r_count;
  end
`endif

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
    end
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
`ifdef CHAN_ENDPOINT_STATUS_EN
    // Flush wins over everything else happening this edge.
    if (w_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end
`endif
  end

  always_ff @(posedge clk_fx2 or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage needs no reset: contents are only visible while count > 0.
  always_ff @(posedge clk_fx2) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= h2fData;
    end
  end

  // --------------------------------------------------------------------------
  // Response mux (combinational from chanAddr and registered state)
  // --------------------------------------------------------------------------
  always_comb begin
    h2fReady = 1'b1;
    f2hValid = 1'b1;
    f2hData  = 8'h00;
    if (w_sel_reg) begin
      f2hData = w_reg_rd;
    end else if (w_sel_fifo) begin
      h2fReady = !w_full;
      f2hValid = !w_empty;
      if (!w_empty) begin
        f2hData = r_mem[r_rd_ptr];
      end
    end
`ifdef CHAN_ENDPOINT_STATUS_EN
    else if (w_sel_stat) begin
      f2hData = w_stat_byte;
    end
`endif
  end

endmodule
`default_nettype wire
